data_sram_responder: RTL and testbench

Target-side model of the CPU data SRAM port. It answers the core's en/wen/addr/wdata requests with registered read data one cycle later. It decodes each request to one of two targets: an internal byte-writable word RAM, or a small MMIO register block (LED, switch, free-running timer, sim-done flag). It sits outside the core in the SoC and bench, directly on the core's data_sram_* outputs.

---
 rtl/data_sram_responder.sv | 118 +++++++++++
 tb/tb_data_sram_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data SRAM target for the core: byte-writable word RAM plus a small MMIO
// block (LED, switches, free-running timer, sim-done flag), read data registered.
module data_sram_responder #(
  parameter int unsigned RAM_AW    = 12,
  parameter logic [12:0] MMIO_SEG  = 13'h1FAF,
  parameter logic [31:0] TIMER_RST = 32'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [3:0]  wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [7:0]  switch_in,
  output logic [15:0] led,
  output logic        sim_done,
  output logic [31:0] timer
);

  localparam logic [13:0] OFF_LED    = 14'd0;
  localparam logic [13:0] OFF_SWITCH = 14'd1;
  localparam logic [13:0] OFF_TIMER  = 14'd2;
  localparam logic [13:0] OFF_FLAG   = 14'd3;

  logic [31:0]       ram [0:(1 << RAM_AW) - 1];
  logic [RAM_AW-1:0] ram_idx;
  logic [13:0]       mmio_off;
  logic              is_mmio;
  logic              rd_req;
  logic              wr_req;
  logic              ram_wr;
  logic              mmio_wr;
  logic [31:0]       byte_mask;
  logic [15:0]       led_next;
  logic [31:0]       timer_next;
  logic              sim_done_next;
  logic [31:0]       mmio_rdata;
  logic [7:0]        sw_meta;
  logic [7:0]        sw_sync;
  logic              unused_addr;

  // kseg selector bits and byte offset take no part in decode
  assign unused_addr = ^{addr[31:29], addr[1:0]};

  assign ram_idx  = addr[RAM_AW+1:2];
  assign mmio_off = addr[15:2];
  assign is_mmio  = (addr[28:16] == MMIO_SEG);
  assign rd_req   = en && (wen == 4'b0000);
  assign wr_req   = en && (wen != 4'b0000);
  assign ram_wr   = wr_req && !is_mmio && resetn;
  assign mmio_wr  = wr_req && is_mmio;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign byte_mask[8*gi +: 8] = {8{wen[gi]}};
    end
  endgenerate

  always_comb begin
    led_next      = led;
    timer_next    = timer + 32'd1;
    sim_done_next = sim_done;
    if (mmio_wr) begin
      case (mmio_off)
        OFF_LED:   led_next = (led & ~byte_mask[15:0]) | (wdata[15:0] & byte_mask[15:0]);
        // a load replaces this cycle's increment, merged against the current count
        OFF_TIMER: timer_next = (timer & ~byte_mask) | (wdata & byte_mask);
        OFF_FLAG:  if (wen[0]) sim_done_next = wdata[0];
        default:   ;
      endcase
    end
  end

  always_comb begin
    mmio_rdata = 32'h0;
    case (mmio_off)
      OFF_LED:    mmio_rdata = {16'h0, led};
      OFF_SWITCH: mmio_rdata = {24'h0, sw_sync};
      OFF_TIMER:  mmio_rdata = timer;
      OFF_FLAG:   mmio_rdata = {31'h0, sim_done};
      default:    mmio_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) ram[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata <= 32'h0;
    end else if (rd_req) begin
      rdata <= is_mmio ? mmio_rdata : ram[ram_idx];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      led      <= 16'h0;
      timer    <= TIMER_RST;
      sim_done <= 1'b0;
      sw_meta  <= 8'h0;
      sw_sync  <= 8'h0;
    end else begin
      led      <= led_next;
      timer    <= timer_next;
      sim_done <= sim_done_next;
      sw_meta  <= switch_in;
      sw_sync  <= sw_meta;
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Self-checking bench for data_sram_responder: vector table for RAM/LED paths,
// hand sequences for timer wrap, switch sync, sim flag and mid-read reset.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  switch_in;
  logic [15:0] led;
  logic        sim_done;
  logic [31:0] timer;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    bit          chk;
    string       nm;
  } vec_t;

  vec_t vecs [20];

  data_sram_responder dut (
    .clk(clk), .resetn(resetn), .en(en), .wen(wen), .addr(addr),
    .wdata(wdata), .rdata(rdata), .switch_in(switch_in), .led(led),
    .sim_done(sim_done), .timer(timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // one request cycle; when chk is set the expected rdata after the edge is queued
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] ex, input bit chk,
                     input string nm);
    logic [31:0] expv;
    en = e; wen = w; addr = a; wdata = d;
    if (chk) exp_q.push_back(ex);
    @(posedge clk); #1;
    en = 1'b0; wen = 4'h0;
    if (chk) begin
      expv = exp_q.pop_front();
      check(nm, rdata, expv);
    end
  endtask

  initial begin
    vecs[0]  = '{1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344, 32'h0,          1'b0, "ram_wr_full"};
    vecs[1]  = '{1'b1, 4'h5, 32'h0000_0100, 32'hAABB_CCDD, 32'h0,          1'b0, "ram_wr_part"};
    vecs[2]  = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'h11BB_33DD, 1'b1, "ram_rd_merge"};
    vecs[3]  = '{1'b0, 4'h0, 32'h0,         32'h0,         32'h11BB_33DD, 1'b1, "idle_hold"};
    vecs[4]  = '{1'b1, 4'hF, 32'h0000_4100, 32'hCAFE_F00D, 32'h0,          1'b0, "ram_wr_alias"};
    vecs[5]  = '{1'b1, 4'h0, 32'h8000_0100, 32'h0,         32'hCAFE_F00D, 1'b1, "ram_alias"};
    vecs[6]  = '{1'b1, 4'hF, 32'h0000_0204, 32'hDEAD_BEEF, 32'h0,          1'b0, "ram_wr_204"};
    vecs[7]  = '{1'b1, 4'hA, 32'h0000_0204, 32'h5566_7788, 32'hCAFE_F00D, 1'b1, "write_hold"};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0204, 32'h0,         32'h55AD_77EF, 1'b1, "ram_rd_lanes"};
    vecs[9]  = '{1'b1, 4'hF, 32'h0000_3FFC, 32'h0102_0304, 32'h0,          1'b0, "ram_wr_top"};
    vecs[10] = '{1'b1, 4'h0, 32'hA000_3FFC, 32'h0,         32'h0102_0304, 1'b1, "ram_top_word"};
    vecs[11] = '{1'b1, 4'hF, 32'hBFAF_0100, 32'hBAD0_BAD0, 32'h0,          1'b0, "mmio_wr_unmapped"};
    vecs[12] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1'b1, "mmio_no_ram_hit"};
    vecs[13] = '{1'b1, 4'h0, 32'hBFAF_0100, 32'h0,         32'h0,          1'b1, "mmio_unmapped"};
    vecs[14] = '{1'b1, 4'hF, 32'hBFAF_0000, 32'h0001_F0F0, 32'h0,          1'b0, "led_wr"};
    vecs[15] = '{1'b1, 4'h0, 32'hBFAF_0000, 32'h0,         32'h0000_F0F0, 1'b1, "led_rd"};
    vecs[16] = '{1'b1, 4'h2, 32'hBFAF_0000, 32'h0000_3300, 32'h0,          1'b0, "led_wr_lane1"};
    vecs[17] = '{1'b1, 4'h0, 32'h9FAF_0000, 32'h0,         32'h0000_33F0, 1'b1, "led_merge"};
    vecs[18] = '{1'b0, 4'hF, 32'h0000_0100, 32'h0,         32'h0000_33F0, 1'b1, "en0_hold"};
    vecs[19] = '{1'b1, 4'h0, 32'h0000_0100, 32'h0,         32'hCAFE_F00D, 1'b1, "en0_no_write"};

    resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; switch_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", rdata, 32'h0);
    check("rst_led", {16'h0, led}, 32'h0);
    check("rst_timer", timer, 32'h0);
    check("rst_sim_done", {31'h0, sim_done}, 32'h0);
    resetn = 1'b1;

    repeat (5) @(posedge clk);
    #1;
    check("timer_at_5", timer, 32'd5);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, 32'd5, 1'b1, "timer_rd_5");

    for (int i = 0; i < 20; i++) begin
      cyc(vecs[i].en, vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].exp, vecs[i].chk, vecs[i].nm);
    end
    check("led_out", {16'h0, led}, 32'h0000_33F0);

    // timer load and wrap
    cyc(1'b1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFE, 32'h0, 1'b0, "timer_wr");
    check("timer_load", timer, 32'hFFFF_FFFE);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, "idle");
    check("timer_max", timer, 32'hFFFF_FFFF);
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, "idle");
    check("timer_wrap", timer, 32'h0);
    cyc(1'b1, 4'h2, 32'hBFAF_0008, 32'h0000_5500, 32'h0, 1'b0, "timer_wr_lane1");
    check("timer_merge", timer, 32'h0000_5500);
    cyc(1'b1, 4'h0, 32'hBFAF_0008, 32'h0, 32'h0000_5500, 1'b1, "timer_rd_req_val");
    check("timer_incr", timer, 32'h0000_5501);

    // sim flag
    cyc(1'b1, 4'h1, 32'hBFAF_000C, 32'h1, 32'h0, 1'b0, "flag_set");
    check("sim_done_set", {31'h0, sim_done}, 32'h1);
    cyc(1'b1, 4'h2, 32'hBFAF_000C, 32'h0, 32'h0, 1'b0, "flag_lane1");
    check("sim_done_keep", {31'h0, sim_done}, 32'h1);
    cyc(1'b1, 4'h0, 32'hBFAF_000C, 32'h0, 32'h1, 1'b1, "flag_rd");
    cyc(1'b1, 4'h1, 32'hBFAF_000C, 32'hFFFF_FFFE, 32'h0, 1'b0, "flag_clr");
    check("sim_done_clr", {31'h0, sim_done}, 32'h0);
    cyc(1'b1, 4'h1, 32'hBFAF_000C, 32'h1, 32'h0, 1'b0, "flag_set2");
    check("sim_done_set2", {31'h0, sim_done}, 32'h1);

    // switch synchroniser latency
    switch_in = 8'h5A;
    cyc(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, "sw_change");
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, 32'h0, 1'b1, "sw_rd_early");
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, 32'h0000_005A, 1'b1, "sw_rd_sync");
    cyc(1'b1, 4'hF, 32'hBFAF_0004, 32'h0, 32'h0, 1'b0, "sw_wr");
    cyc(1'b1, 4'h0, 32'hBFAF_0004, 32'h0, 32'h0000_005A, 1'b1, "sw_ro");

    // asynchronous reset in the middle of a RAM read
    cyc(1'b1, 4'hF, 32'h0000_0300, 32'h1234_5678, 32'h0, 1'b0, "ram_wr_300");
    en = 1'b1; wen = 4'h0; addr = 32'h0000_0300;
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_rdata", rdata, 32'h0);
    check("midrst_led", {16'h0, led}, 32'h0);
    check("midrst_timer", timer, 32'h0);
    check("midrst_sim_done", {31'h0, sim_done}, 32'h0);
    en = 1'b0;
    @(posedge clk); #1;
    check("inrst_rdata", rdata, 32'h0);
    resetn = 1'b1;
    cyc(1'b1, 4'h0, 32'h0000_0300, 32'h0, 32'h1234_5678, 1'b1, "ram_retained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
